// File: rtl/instr_encoder_loader.sv
// Instruction loader: packs symbolic requests into 9-bit {opcode, field} words
// and writes them to instruction memory from address 0 until a halt is written.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | session active, accepting requests
// DONE  | halt written, waiting for start
// ERR   | session aborted (illegal op/sub-op or overflow), waiting for start
module instr_encoder_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [1:0]        req_rd,
   input  logic [2:0]        req_sub,
   input  logic [4:0]        req_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [8:0]        imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   state_t     state;
   logic [4:0] field;
   logic       op_bad;
   logic       sub_bad;
   logic       is_halt;
   logic       accept;

   assign accept = req_valid && req_ready;

   // Field packing and legality of the presented request.
   always_comb begin
      field   = 5'b0;
      op_bad  = 1'b0;
      sub_bad = 1'b0;
      is_halt = 1'b0;
      case (req_op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b1001: field = {req_rd, 3'b000};
         4'b0110:                   field = {2'b00, req_sub};
         4'b0111: begin
            field   = {req_rd, req_sub};
            sub_bad = (req_sub > 3'b100);
            is_halt = (req_sub == 3'b010);
         end
         4'b1010, 4'b1011, 4'b1100,
         4'b1101, 4'b1110:          field = req_imm;
         default:                   op_bad = 1'b1;
      endcase
   end

   // Session FSM with registered handshake, write port and status.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         req_ready  <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'b00;
         word_count <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_LOAD: begin
               if (accept) begin
                  if (word_count == DEPTH_LIM) begin
                     state     <= S_ERR;
                     req_ready <= 1'b0;
                     busy      <= 1'b0;
                     err       <= 1'b1;
                     err_code  <= 2'b11;
                  end else if (op_bad || sub_bad) begin
                     // Address is presented so the failing slot is visible.
                     state     <= S_ERR;
                     req_ready <= 1'b0;
                     busy      <= 1'b0;
                     err       <= 1'b1;
                     err_code  <= op_bad ? 2'b01 : 2'b10;
                     imem_addr <= word_count[ADDR_W-1:0];
                  end else begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_count[ADDR_W-1:0];
                     imem_wdata <= {req_op, field};
                     word_count <= word_count + (ADDR_W+1)'(1);
                     if (is_halt) begin
                        state     <= S_DONE;
                        req_ready <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               if (start) begin
                  state      <= S_LOAD;
                  req_ready  <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  err_code   <= 2'b00;
                  word_count <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with a small memory (DEPTH=4).
module tb_instr_encoder_loader;

   localparam int AW  = 3;
   localparam int DEP = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    req_op = '0;
   logic [1:0]    req_rd = '0;
   logic [2:0]    req_sub = '0;
   logic [4:0]    req_imm = '0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [8:0]    imem_wdata;
   logic          busy, done, err;
   logic [1:0]    err_code;
   logic [AW:0]   word_count;

   instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DEP)) dut (
      .clock(clock), .reset(reset), .start(start),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_sub(req_sub), .req_imm(req_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .word_count(word_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] op;
      logic [1:0] rd;
      logic [2:0] sub;
      logic [4:0] imm;
   } req_t;

   typedef struct {
      int         addr;
      logic [8:0] data;
   } wr_t;

   int   tests = 0;
   int   fails = 0;
   wr_t  expq[$];
   req_t dq[$];

   // reference session state
   int   m_count;
   bit   m_load, m_done, m_err;
   int   m_code;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] encode(input req_t r);
      logic [4:0] f;
      case (r.op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9: f = {r.rd, 3'b000};
         4'd6:                                     f = {2'b00, r.sub};
         4'd7:                                     f = {r.rd, r.sub};
         4'd10, 4'd11, 4'd12, 4'd13, 4'd14:        f = r.imm;
         default:                                  f = 5'd0;
      endcase
      return {r.op, f};
   endfunction

   task automatic model_accept(input req_t r);
      wr_t w;
      if (m_count == DEP) begin
         m_err = 1; m_code = 3; m_load = 0;
      end else if (r.op == 4'd8 || r.op == 4'd15) begin
         m_err = 1; m_code = 1; m_load = 0;
      end else if (r.op == 4'd7 && r.sub > 3'd4) begin
         m_err = 1; m_code = 2; m_load = 0;
      end else begin
         w.addr = m_count;
         w.data = encode(r);
         expq.push_back(w);
         m_count++;
         if (r.op == 4'd7 && r.sub == 3'd2) begin
            m_done = 1; m_load = 0;
         end
      end
   endtask

   function automatic req_t mk(input int op, input int rd, input int sub, input int imm);
      req_t r;
      r.op = 4'(op); r.rd = 2'(rd); r.sub = 3'(sub); r.imm = 5'(imm);
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r = mk($urandom_range(15), $urandom_range(3), $urandom_range(7), $urandom_range(31));
      if ((r.op == 4'd8 || r.op == 4'd15) && $urandom_range(3) != 0) r.op = 4'($urandom_range(7));
      if ($urandom_range(5) == 0) begin r.op = 4'd7; r.sub = 3'd2; end
      return r;
   endfunction

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clock) begin
      wr_t e;
      if (!reset && imem_we) begin
         if (expq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write got addr=%0d data=%h want none", imem_addr, imem_wdata);
         end else begin
            e = expq.pop_front();
            check("write_addr", int'(imem_addr), e.addr);
            check("write_data", int'(imem_wdata), int'(e.data));
         end
      end
   end

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      m_count = 0; m_load = 1; m_done = 0; m_err = 0; m_code = 0;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run_session(input bit use_dq, input int valid_pct);
      req_t r;
      bit   v;
      int   cyc;
      pulse_start();
      cyc = 0;
      while (m_load && cyc < 60) begin
         if (cyc > 0) @(negedge clock);
         check("req_ready_load", int'(req_ready), 1);
         check("busy_load", int'(busy), 1);
         r = (use_dq && dq.size() > 0) ? dq[0] : rand_req();
         v = use_dq ? 1'b1 : ($urandom_range(99) < valid_pct);
         req_valid = v;
         req_op = r.op; req_rd = r.rd; req_sub = r.sub; req_imm = r.imm;
         start = (!use_dq && $urandom_range(7) == 0);
         @(posedge clock);
         if (v) begin
            model_accept(r);
            if (use_dq && dq.size() > 0) void'(dq.pop_front());
         end
         cyc++;
      end
      if (m_load) begin
         tests++; fails++;
         $display("FAIL session_timeout got still_loading want ended");
         m_load = 0;
      end
      @(negedge clock);
      req_valid = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clock);
      check("done", int'(done), int'(m_done));
      check("err", int'(err), int'(m_err));
      check("err_code", int'(err_code), m_code);
      check("word_count", int'(word_count), m_count);
      check("busy_end", int'(busy), 0);
      check("req_ready_end", int'(req_ready), 0);
      check("writes_pending", expq.size(), 0);
      dq.delete();
   endtask

   initial begin
      #2 reset = 1'b1;
      #1;
      check("rst_ready", int'(req_ready), 0);
      check("rst_we", int'(imem_we), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_wc", int'(word_count), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check("idle_ready", int'(req_ready), 0);

      // add r2, sl r1, halt
      dq.push_back(mk(0, 2, 0, 0));
      dq.push_back(mk(3, 1, 0, 0));
      dq.push_back(mk(7, 0, 2, 0));
      run_session(1, 100);

      // back-to-back immediates, halt lands at DEPTH-1
      dq.push_back(mk(10, 0, 0, 5'b10110));
      dq.push_back(mk(12, 0, 0, 5'b00011));
      dq.push_back(mk(14, 0, 0, 5'b11111));
      dq.push_back(mk(7, 0, 2, 0));
      run_session(1, 100);

      // illegal opcode after one word
      dq.push_back(mk(0, 0, 0, 0));
      dq.push_back(mk(15, 0, 0, 0));
      run_session(1, 100);

      // illegal special sub-op
      dq.push_back(mk(7, 1, 6, 0));
      run_session(1, 100);

      // overflow: four words then a fifth request
      dq.push_back(mk(1, 1, 0, 0));
      dq.push_back(mk(6, 0, 5, 0));
      dq.push_back(mk(9, 3, 0, 0));
      dq.push_back(mk(7, 2, 4, 0));
      dq.push_back(mk(2, 0, 0, 0));
      run_session(1, 100);

      // randomized sessions (random start pulses during LOAD must be ignored)
      for (int s = 0; s < 40; s++) run_session(0, 70);

      // async reset right after an accept drops the pending strobe
      pulse_start();
      req_valid = 1'b1;
      req_op = 4'd0; req_rd = 2'd3; req_sub = '0; req_imm = '0;
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      check("arst_we", int'(imem_we), 0);
      check("arst_addr", int'(imem_addr), 0);
      check("arst_wdata", int'(imem_wdata), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_ready", int'(req_ready), 0);
      check("arst_wc", int'(word_count), 0);
      check("arst_done_err", int'({done, err, err_code}), 0);
      req_valid = 1'b0;
      m_load = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check("arst_idle_ready", int'(req_ready), 0);

      // a fresh session after reset starts at address 0
      dq.push_back(mk(7, 0, 2, 0));
      run_session(1, 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
